// File: rtl/tor_switch_model.sv
// ---------------------------------------------------------------------------
// tor_switch_model
// Behavioural top-of-rack switch model connecting NUM_PORTS NIC network lines.
// Each input has an ingress FIFO. Each output picks one matching FIFO head
// per cycle with round-robin arbitration. The winner then passes through a
// fixed LATENCY-stage delay line before it reaches the tx side.
//
// Ports
//   clk            : single clock
//   reset_n        : synchronous, active-low reset
//   rx_valid[i]    : frame strobe from NIC i (no backpressure)
//   rx_data[i]     : frame payload from NIC i
//   rx_dest[i]     : destination NIC_ID of the frame from NIC i
//   tx_valid[o]    : frame strobe toward NIC o
//   tx_data[o]     : delivered payload (zero while tx_valid[o]=0)
//   tx_src[o]      : source port of delivered frame (zero while idle)
//   drop_full_cnt  : saturating count of frames lost to a full ingress FIFO
//   drop_dest_cnt  : saturating count of frames with rx_dest >= NUM_PORTS
// ---------------------------------------------------------------------------
module tor_switch_model #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 8,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_PORTS-1:0]                 rx_valid,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]     rx_data,
    input  logic [NUM_PORTS-1:0][ID_W-1:0]       rx_dest,
    output logic [NUM_PORTS-1:0]                 tx_valid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]     tx_data,
    output logic [NUM_PORTS-1:0][ID_W-1:0]       tx_src,
    output logic [31:0]                          drop_full_cnt,
    output logic [31:0]                          drop_dest_cnt
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Low during reset and for the first edge after release, so that the
    // release edge itself never accepts a frame.
    logic                                r_rx_en;

    logic [NUM_PORTS-1:0]                w_head_vld;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    w_head_data;
    logic [NUM_PORTS-1:0][ID_W-1:0]      w_head_dest;
    logic [NUM_PORTS-1:0]                w_pop;
    logic [NUM_PORTS-1:0]                w_drop_full;
    logic [NUM_PORTS-1:0]                w_drop_dest;
    logic [NUM_PORTS-1:0]                w_gnt_vld;
    logic [NUM_PORTS-1:0][IDX_W-1:0]     w_gnt_idx;

    logic [31:0]                         r_drop_full_cnt;
    logic [31:0]                         r_drop_dest_cnt;
    logic [32:0]                         w_full_sum;
    logic [32:0]                         w_dest_sum;

    always_ff @(posedge clk) begin
        if (!reset_n) r_rx_en <= 1'b0;
        else          r_rx_en <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Ingress FIFOs, one per input
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
        logic [ID_W-1:0]   r_mem_dest [FIFO_DEPTH];
        logic [PTR_W-1:0]  r_wptr;
        logic [PTR_W-1:0]  r_rptr;
        logic [CNT_W-1:0]  r_count;
        logic              w_dest_ok;
        logic              w_full;
        logic              w_push;
        logic              w_pop_i;

        assign w_dest_ok = 32'(rx_dest[gi]) < 32'(NUM_PORTS);
        // Full is judged on the registered count only: a pop on the same
        // edge does not make room for the incoming frame.
        assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
        assign w_push    = r_rx_en && rx_valid[gi] && w_dest_ok && !w_full;

        assign w_drop_dest[gi] = r_rx_en && rx_valid[gi] && !w_dest_ok;
        assign w_drop_full[gi] = r_rx_en && rx_valid[gi] && w_dest_ok && w_full;

        assign w_head_vld[gi]  = (r_count != '0);
        assign w_head_data[gi] = r_mem_data[r_rptr];
        assign w_head_dest[gi] = r_mem_dest[r_rptr];

        // An input head has exactly one destination, so at most one output
        // can grant it.
        always_comb begin
            w_pop_i = 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_gnt_vld[o] && (w_gnt_idx[o] == IDX_W'(gi))) w_pop_i = 1'b1;
            end
        end
        assign w_pop[gi] = w_pop_i;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem_data[r_wptr] <= rx_data[gi];
                r_mem_dest[r_wptr] <= rx_dest[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)     r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop_i)    r_rptr <= r_rptr + PTR_W'(1);
                case ({w_push, w_pop_i})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-output round-robin arbiter and delay line
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
        logic [IDX_W-1:0]  r_last;
        logic              w_vld;
        logic [IDX_W-1:0]  w_idx;
        int                w_cand;
        logic              r_dl_vld  [LATENCY];
        logic [DATA_W-1:0] r_dl_data [LATENCY];
        logic [ID_W-1:0]   r_dl_src  [LATENCY];

        // Search order starts one past the last winner and wraps.
        always_comb begin
            w_vld  = 1'b0;
            w_idx  = '0;
            w_cand = 0;
            for (int k = 1; k <= NUM_PORTS; k++) begin
                w_cand = (int'(r_last) + k) % NUM_PORTS;
                if (!w_vld && w_head_vld[IDX_W'(w_cand)] &&
                    (int'(w_head_dest[IDX_W'(w_cand)]) == gi)) begin
                    w_vld = 1'b1;
                    w_idx = IDX_W'(w_cand);
                end
            end
        end

        assign w_gnt_vld[gi] = w_vld;
        assign w_gnt_idx[gi] = w_idx;

        always_ff @(posedge clk) begin
            if (!reset_n)   r_last <= IDX_W'(NUM_PORTS - 1);
            else if (w_vld) r_last <= w_idx;
        end

        // Payload and source are zeroed on entry when no frame is granted,
        // so the idle tx side reads zero without extra output muxing.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int s = 0; s < LATENCY; s++) begin
                    r_dl_vld[s]  <= 1'b0;
                    r_dl_data[s] <= '0;
                    r_dl_src[s]  <= '0;
                end
            end else begin
                r_dl_vld[0]  <= w_vld;
                r_dl_data[0] <= w_vld ? w_head_data[w_idx] : '0;
                r_dl_src[0]  <= w_vld ? ID_W'(w_idx) : '0;
                for (int s = 1; s < LATENCY; s++) begin
                    r_dl_vld[s]  <= r_dl_vld[s-1];
                    r_dl_data[s] <= r_dl_data[s-1];
                    r_dl_src[s]  <= r_dl_src[s-1];
                end
            end
        end

        assign tx_valid[gi] = r_dl_vld[LATENCY-1];
        assign tx_data[gi]  = r_dl_data[LATENCY-1];
        assign tx_src[gi]   = r_dl_src[LATENCY-1];
    end

    // ------------------------------------------------------------------
    // Drop counters: per-port drops in one cycle are summed, then the total
    // clamps at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_full_sum = {1'b0, r_drop_full_cnt};
        w_dest_sum = {1'b0, r_drop_dest_cnt};
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_full_sum = w_full_sum + 33'(w_drop_full[i]);
            w_dest_sum = w_dest_sum + 33'(w_drop_dest[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_drop_full_cnt <= '0;
            r_drop_dest_cnt <= '0;
        end else begin
            r_drop_full_cnt <= w_full_sum[32] ? 32'hFFFF_FFFF : w_full_sum[31:0];
            r_drop_dest_cnt <= w_dest_sum[32] ? 32'hFFFF_FFFF : w_dest_sum[31:0];
        end
    end

    assign drop_full_cnt = r_drop_full_cnt;
    assign drop_dest_cnt = r_drop_dest_cnt;

endmodule

// File: tb/tb_tor_switch_model.sv
// ---------------------------------------------------------------------------
// tb_tor_switch_model
// Directed bench for tor_switch_model (NUM_PORTS=2, LATENCY=4, FIFO_DEPTH=4).
// A monitor logs every delivered frame, one line per frame, into per-output
// queues. The main sequence drives the stimulus and compares the results
// against values worked out by hand.
// Payload coding for ordering tests: data[31:0] = {src[15:0], seq[15:0]}.
// ---------------------------------------------------------------------------
module tb_tor_switch_model;

    localparam int NP  = 2;
    localparam int DW  = 512;
    localparam int IW  = 8;
    localparam int LAT = 4;
    localparam int FD  = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NP-1:0]           rx_valid;
    logic [NP-1:0][DW-1:0]   rx_data;
    logic [NP-1:0][IW-1:0]   rx_dest;
    logic [NP-1:0]           tx_valid;
    logic [NP-1:0][DW-1:0]   tx_data;
    logic [NP-1:0][IW-1:0]   tx_src;
    logic [31:0]             drop_full_cnt;
    logic [31:0]             drop_dest_cnt;

    tor_switch_model #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .ID_W      (IW),
        .LATENCY   (LAT),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_dest      (rx_dest),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_src       (tx_src),
        .drop_full_cnt(drop_full_cnt),
        .drop_dest_cnt(drop_dest_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [31:0] dat;
        int          cyc;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: log delivered frames; idle outputs must present zeros.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_valid[0]) begin
                q0.push_back('{int'(tx_src[0]), tx_data[0][31:0], cyc});
                $display("[TB] out0 src=%0d data=%08h cyc=%0d", tx_src[0], tx_data[0][31:0], cyc);
            end else begin
                check("idle_zero_o0", DW'((|tx_data[0]) | (|tx_src[0])), DW'(0));
            end
            if (tx_valid[1]) begin
                q1.push_back('{int'(tx_src[1]), tx_data[1][31:0], cyc});
                $display("[TB] out1 src=%0d data=%08h cyc=%0d", tx_src[1], tx_data[1][31:0], cyc);
            end else begin
                check("idle_zero_o1", DW'((|tx_data[1]) | (|tx_src[1])), DW'(0));
            end
        end
    end

    task automatic drive(input logic [NP-1:0] v, input int d0, input int d1,
                         input logic [31:0] x0, input logic [31:0] x1);
        rx_valid   = v;
        rx_dest[0] = IW'(d0);
        rx_dest[1] = IW'(d1);
        rx_data[0] = DW'(x0);
        rx_data[1] = DW'(x1);
    endtask

    task automatic idle(input int n);
        rx_valid = '0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = '0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        q0.delete();
        q1.delete();
    endtask

    // One frame port0 -> output1; tx_valid[1] must pulse exactly on the 5th
    // edge after the frame is presented, for one cycle only.
    task automatic single_latency(input string tag);
        logic [DW-1:0] pat;
        pat        = {64{8'hA5}};
        rx_valid   = 2'b01;
        rx_dest[0] = IW'(1);
        rx_data[0] = pat;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) rx_valid = '0;
            check($sformatf("%s_vld_c%0d", tag, c), DW'(tx_valid[1]), DW'(c == 5));
            if (c == 5) begin
                check({tag, "_src"},  DW'(tx_src[1]),   DW'(0));
                check({tag, "_data"}, tx_data[1],       pat);
                check({tag, "_o0"},   DW'(tx_valid[0]), DW'(0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int s0[$];
        int s1[$];
        int exp0[13] = '{0, 1, 2, 3, 4, 5, 6, 8, 10, 12, 14, 16, 18};
        int exp1[13] = '{0, 1, 2, 3, 4, 5, 7, 9, 11, 13, 15, 17, 19};

        // ---- Reset state; rx_valid held during reset and release edge ----
        reset_n = 1'b0;
        drive(2'b01, 1, 0, 32'h0000_0077, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rx_valid = '0;
        check("rst_tx_valid", DW'(tx_valid), DW'(0));
        check("rst_tx_data0", tx_data[0], DW'(0));
        check("rst_tx_data1", tx_data[1], DW'(0));
        check("rst_tx_src",   DW'(tx_src), DW'(0));
        check("rst_full_cnt", DW'(drop_full_cnt), DW'(0));
        check("rst_dest_cnt", DW'(drop_dest_cnt), DW'(0));
        mon_en = 1'b1;
        idle(10);
        check("rst_rx_ignored", DW'(q0.size() + q1.size()), DW'(0));

        // ---- Single frame, nominal latency ----
        do_reset();
        single_latency("single");

        // ---- Contention: both ports to output 1 for 3 cycles ----
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1, 1, {16'd0, 16'(k)}, {16'd1, 16'(k)});
            @(negedge clk);
        end
        idle(15);
        check("cont_count", DW'(q1.size()), DW'(6));
        check("cont_o0",    DW'(q0.size()), DW'(0));
        for (int i = 0; i < q1.size() && i < 6; i++) begin
            check($sformatf("cont_src%0d", i), DW'(q1[i].src), DW'(i % 2));
            check($sformatf("cont_dat%0d", i), DW'(q1[i].dat), DW'({16'(i % 2), 16'(i / 2)}));
            check($sformatf("cont_cyc%0d", i), DW'(q1[i].cyc), DW'(t0 + 5 + i));
        end

        // ---- Overflow: 20 cycles of both ports to output 1, depth 4 ----
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(2'b11, 1, 1, {16'd0, 16'(k)}, {16'd1, 16'(k)});
            @(negedge clk);
        end
        idle(60);
        check("ovf_full_cnt", DW'(drop_full_cnt), DW'(14));
        check("ovf_dest_cnt", DW'(drop_dest_cnt), DW'(0));
        check("ovf_delivered", DW'(q1.size()), DW'(26));
        foreach (q1[i]) begin
            if (q1[i].src == 0) s0.push_back(int'(q1[i].dat[15:0]));
            else                s1.push_back(int'(q1[i].dat[15:0]));
        end
        check("ovf_p0_count", DW'(s0.size()), DW'(13));
        check("ovf_p1_count", DW'(s1.size()), DW'(13));
        for (int i = 0; i < s0.size() && i < 13; i++)
            check($sformatf("ovf_p0_seq%0d", i), DW'(s0[i]), DW'(exp0[i]));
        for (int i = 0; i < s1.size() && i < 13; i++)
            check($sformatf("ovf_p1_seq%0d", i), DW'(s1[i]), DW'(exp1[i]));

        // ---- Bad destination ----
        do_reset();
        drive(2'b10, 0, 2, 32'h0, 32'h0000_0022);
        @(negedge clk);
        idle(10);
        check("bad_no_tx",    DW'(q0.size() + q1.size()), DW'(0));
        check("bad_dest_cnt", DW'(drop_dest_cnt), DW'(1));
        check("bad_full_cnt", DW'(drop_full_cnt), DW'(0));
        drive(2'b11, 7, 3, 32'h0, 32'h0);
        @(negedge clk);
        rx_valid = '0;
        check("bad_two_ports", DW'(drop_dest_cnt), DW'(3));

        // ---- Reset mid-flight ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1, 3, {16'd0, 16'(k)}, 32'h0);
            @(negedge clk);
        end
        rx_valid = '0;
        @(negedge clk);
        check("mid_pre_cnt", DW'(drop_dest_cnt), DW'(3));
        check("mid_pre_tx",  DW'(tx_valid), DW'(0));
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx",  DW'(tx_valid), DW'(0));
        check("mid_rst_cnt", DW'(drop_dest_cnt), DW'(0));
        reset_n = 1'b1;
        @(negedge clk);
        idle(10);
        check("mid_no_tx",   DW'(q0.size() + q1.size()), DW'(0));
        check("mid_cnt_post", DW'(drop_dest_cnt | drop_full_cnt), DW'(0));
        single_latency("mid_next");

        // ---- Self-loop with drop_dest_cnt saturation ----
        do_reset();
        force dut.r_drop_dest_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_drop_dest_cnt;
        @(negedge clk);
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 0, 5, {16'd0, 16'(k)}, 32'h0000_0055);
            @(negedge clk);
            check($sformatf("sat_cnt%0d", k), DW'(drop_dest_cnt), DW'(32'hFFFF_FFFF));
        end
        idle(12);
        check("loop_count", DW'(q0.size()), DW'(3));
        check("loop_o1",    DW'(q1.size()), DW'(0));
        for (int i = 0; i < q0.size() && i < 3; i++) begin
            check($sformatf("loop_src%0d", i), DW'(q0[i].src), DW'(0));
            check($sformatf("loop_dat%0d", i), DW'(q0[i].dat), DW'({16'd0, 16'(i)}));
            check($sformatf("loop_cyc%0d", i), DW'(q0[i].cyc), DW'(t0 + 5 + i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tor_switch_model.md
TOR_SWITCH_MODEL -- requirements
Module: tor_switch_model

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of attached NIC network lines.
REQ-002 Parameter DATA_W, default 512: frame payload width in bits.
REQ-003 Parameter ID_W, default 8: destination NIC_ID width.
REQ-004 Parameter LATENCY, default 4, legal range 1..64: fixed wire delay in cycles after arbitration.
REQ-005 Parameter FIFO_DEPTH, default 16, power of two, >=2: ingress FIFO depth per input port.
REQ-006 Port clk  in  1: single clock for all logic.
REQ-007 Port reset_n  in  1: reset, synchronous to clk and active-low.
REQ-008 Port rx_valid  in  NUM_PORTS: per-port frame strobe from NIC network_tx_out; no backpressure.
REQ-009 Port rx_data  in  NUM_PORTS x DATA_W: per-port frame payload.
REQ-010 Port rx_dest  in  NUM_PORTS x ID_W: per-port destination NIC_ID.
REQ-011 Port tx_valid  out  NUM_PORTS: per-port frame strobe toward NIC network_rx_in.
REQ-012 Port tx_data  out  NUM_PORTS x DATA_W: per-port delivered payload.
REQ-013 Port tx_src  out  NUM_PORTS x ID_W: source port index of the delivered frame, zero-extended.
REQ-014 Port drop_full_cnt  out  32: frames dropped because the ingress FIFO was full.
REQ-015 Port drop_dest_cnt  out  32: frames dropped because rx_dest >= NUM_PORTS.

Function
REQ-016 Ingress: a frame with rx_valid[i]=1 at edge t SHALL be written into ingress FIFO i at t and SHALL be visible at the FIFO head in cycle t+1.
REQ-017 If rx_dest[i] >= NUM_PORTS, the frame SHALL NOT be written, and drop_dest_cnt SHALL increment by 1.
REQ-018 Full check: if FIFO i occupancy equals FIFO_DEPTH at edge t, the frame SHALL be dropped and drop_full_cnt SHALL increment by 1, even if the same edge pops FIFO i.
REQ-019 Occupancy SHALL be a registered count, range 0..FIFO_DEPTH; the read and write pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop SHALL leave the count unchanged.
REQ-020 Arbitration: each output o SHALL grant at most one non-empty input head per cycle whose dest equals o.
REQ-021 Each output SHALL use round-robin arbitration: the search SHALL start at (last_grant[o]+1) mod NUM_PORTS, and last_grant[o] SHALL update only on a grant.
REQ-022 A granted head SHALL be popped at the same edge; an ungranted head SHALL block its FIFO (head-of-line), and the block SHALL not reorder frames within an input.
REQ-023 Delay: a frame granted in cycle c SHALL enter a LATENCY-stage shift register and SHALL appear on tx_valid/tx_data/tx_src of output o in cycle c+LATENCY.
REQ-024 Unloaded end-to-end latency from an rx_valid edge to tx_valid SHALL be exactly LATENCY+1 cycles.
REQ-025 Sustained throughput with no contention SHALL be one frame per cycle per output.
REQ-026 While tx_valid[o]=0, tx_data[o] and tx_src[o] SHALL be zero.
REQ-027 Drop counters SHALL saturate at 32'hFFFFFFFF and SHALL not wrap.
REQ-028 If a full drop and a dest drop occur on different ports in the same cycle, each counter SHALL increment by one per offending port (multi-port adds summed).
REQ-029 A frame with rx_dest == i from input i (self-loop) SHALL be legal and SHALL be delivered on output i.

Reset
REQ-030 While reset_n=0 at a clk edge: all FIFOs empty, all delay stages invalid, tx_valid=0, tx_data=0, tx_src=0, both counters=0, last_grant[o]=NUM_PORTS-1.
REQ-031 A reset asserted mid-operation SHALL discard all queued and in-flight frames with no partial delivery.
REQ-032 rx_valid SHALL be ignored during reset and in the cycle of reset release.

Verification
REQ-033 Single frame: port0 sends dest=1, data=0xA5.., LATENCY=4 -> tx_valid[1]=1 exactly 5 cycles later, tx_src[1]=0, data matches, tx_valid[0] stays 0.
REQ-034 Contention: ports 0 and 1 both send dest=1 in the same cycle, 3 consecutive cycles -> output 1 delivers 6 frames back-to-back, order src 0,1,0,1,0,1.
REQ-035 Overflow: port0 sends 20 frames to dest=1 while output 1 is saturated by port1 traffic -> the FIFO fills, drop_full_cnt increments by exactly the count of frames beyond capacity, and surviving frames arrive in order.
REQ-036 Bad destination: port1 sends dest=2 with NUM_PORTS=2 -> no tx_valid on any port, drop_dest_cnt=1.
REQ-037 Reset mid-flight: reset_n=0 for 1 cycle while 3 frames are in the delay line -> no tx_valid afterwards, counters=0, and the next frame sees nominal latency.
REQ-038 Self-loop plus counter saturation: force drop_dest_cnt to 32'hFFFFFFFE, then issue 3 bad-dest frames -> the counter holds at 32'hFFFFFFFF, and concurrent dest=0 traffic from port0 is delivered on output 0.
